// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_pkg
// Brief    : Shared state encoding and parameter defaults for pc_sequencer.
// Revision : 1.0
// ============================================================================
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int          DEF_WIDTH    = 16;
    localparam int          DEF_INC      = 2;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam int          DEF_DEPTH    = 4;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack
// Brief    : Circular return-address LIFO; a full push overwrites the oldest.
// Revision : 1.0
// ============================================================================
module ras_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    sp_q, sp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    top_idx;

    // sp_q is the next write slot; the pointer wraps, so when full it points at the oldest entry
    assign top_idx = sp_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign count   = count_q;

    always_comb begin
        mem_d     = mem_q;
        sp_d      = sp_q;
        count_d   = count_q;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (pop) begin
            if (count_q == '0) begin
                underflow = 1'b1;
            end else begin
                sp_d    = top_idx;
                count_d = count_q - CW'(1);
            end
        end else if (push) begin
            mem_d[sp_q] = push_data;
            sp_d        = sp_q + PW'(1);
            if (count_q == FULL) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : PC stage driving an external adder, with redirects and a RAS.
// Revision : 1.0
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(DEF_RESET_PC),
    parameter int               INC         = DEF_INC,
    parameter int               STACK_DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             advance,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             branchTake,
    input  logic [WIDTH-1:0] branchOffset,
    input  logic             jumpTake,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jumpTarget,
    output logic [WIDTH-1:0] addA,
    output logic [WIDTH-1:0] addB,
    input  logic [WIDTH-1:0] addSum,
    output logic [WIDTH-1:0] pcOut,
    output logic             pcValid,
    output logic             stackOverflow,
    output logic             stackUnderflow
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    state_e                      state_q, state_d;
    logic [WIDTH-1:0]            pc_q, pc_d;
    logic                        ovf_q, ovf_d;
    logic                        unf_q, unf_d;
    logic                        update;
    logic                        ras_push, ras_pop;
    logic [WIDTH-1:0]            ras_top;
    logic [$clog2(STACK_DEPTH):0] ras_count;
    logic                        ras_overflow, ras_underflow;

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .resetN    (resetN),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (addSum),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN:  if (halt) state_d = ST_HALT;
                ST_HALT: if (resume && !halt) state_d = ST_RUN;
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        pcValid        = (state_q == ST_RUN);
        pcOut          = pc_q;
        addA           = pc_q;
        addB           = branchTake ? branchOffset : INC_W;
        stackOverflow  = ovf_q;
        stackUnderflow = unf_q;
    end

    // A halting cycle leaves the PC where it is even if fetch accepted it
    assign update = (state_q == ST_RUN) && advance && !stall && !halt;

    always_comb begin
        pc_d     = pc_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (update) begin
            if (ret) begin
                ras_pop = 1'b1;
                pc_d    = (ras_count == '0) ? (pc_q + INC_W) : ras_top;
            end else if (call) begin
                ras_push = 1'b1;
                pc_d     = jumpTarget;
            end else if (jumpTake) begin
                pc_d = jumpTarget;
            end else begin
                pc_d = addSum;
            end
        end
        ovf_d = ovf_q | ras_overflow;
        unf_d = unf_q | ras_underflow;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage that sits directly upstream of adder16bit.
- Holds the architectural PC and drives adder16bit's operands (addA/addB).
- Captures adder16bit's sum, or a redirect target, as the next PC.
- Keeps a small circular return-address stack for call/return; pcOut feeds instruction fetch.

Parameters:
- WIDTH, 16, datapath and PC width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- INC, 2, sequential byte increment per instruction.
- STACK_DEPTH, 4, return-address stack entries; must be a power of two, at least 2.

Ports:
- clk  input  1  single clock, rising-edge.
- resetN  input  1  asynchronous, active-low reset.
- advance  input  1  fetch accepted the current pcOut; PC may update this cycle.
- stall  input  1  hold all state; overrides every other control.
- halt  input  1  enter HALT state.
- resume  input  1  leave HALT state.
- branchTake  input  1  PC-relative redirect.
- branchOffset  input  WIDTH  signed byte offset, two's complement.
- jumpTake  input  1  absolute redirect.
- call  input  1  absolute redirect that also pushes a return address.
- ret  input  1  redirect to the popped return address.
- jumpTarget  input  WIDTH  absolute target used by jumpTake and call.
- addA  output  WIDTH  adder16bit operand A.
- addB  output  WIDTH  adder16bit operand B.
- addSum  input  WIDTH  adder16bit result; combinational, same cycle.
- pcOut  output  WIDTH  current PC.
- pcValid  output  1  pcOut is fetchable.
- stackOverflow  output  1  sticky flag: a push was made while the stack was full.
- stackUnderflow  output  1  sticky flag: a pop was made while the stack was empty.

Behaviour:
- Reset is asynchronous on resetN low.
  - pcOut = RESET_PC, pcValid = 0, stack count = 0, both flags = 0, state = BOOT.
- States and transitions:
  - BOOT: exactly one clock after resetN rises, go to RUN. pcValid = 0 in BOOT.
  - RUN: pcValid = 1.
    - halt=1 (and stall=0) → HALT on the next edge, PC unchanged.
  - HALT: pcValid = 0, PC frozen. resume=1 → RUN on the next edge.
  - halt and resume both high in HALT → stay in HALT.
- Adder operands are combinational and are always driven, in every state:
  - addA = pcOut.
  - addB = branchOffset if branchTake, else INC.
- PC update happens only in RUN with advance=1 and stall=0. Priority, highest first:
  - ret: PC = top of stack; pop.
  - call: push (pcOut+INC), taken from addSum with addB=INC; PC = jumpTarget.
  - jumpTake: PC = jumpTarget.
  - branchTake: PC = addSum.
  - otherwise: PC = addSum, i.e. pcOut+INC.
- call and branchTake are never both high. If they are, call wins, addB = branchOffset, and the pushed value is undefined; the bench does not test this case.
- Arithmetic: wraps modulo 2^WIDTH with no saturation.
  - Example: 16'hFFFE + INC → 16'h0000.
- Stack underflow: ret with count = 0 sets stackUnderflow; PC = pcOut+INC (treated as sequential); count stays 0.
- Stack overflow: call with count = STACK_DEPTH overwrites the oldest entry (circular), sets stackOverflow; count stays STACK_DEPTH.
- ret and call together: ret wins and no push occurs.
- stall high: no state, PC, stack or flag changes in any state.
- Flags clear only on reset.
- resetN asserted mid-operation: all of the above return to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package:
  - state encoding BOOT/RUN/HALT.
  - WIDTH, INC and RESET_PC defaults.
- One natural sub-module: ras_stack.
  - Circular LIFO of depth STACK_DEPTH with push/pop, top-of-stack, count, and overflow/underflow pulses.
  - pc_sequencer holds the sticky flags.
- adder16bit is instantiated beside pc_sequencer by the parent, not inside it.

Test Plan:
- Reset then 3 cycles of advance=1 → pcValid 0 during BOOT; pcOut 0000 → 0002 → 0004; addB = 0002 throughout.
- At pcOut = 0010: branchTake with branchOffset = FFF8 (-8) → next pcOut = 0008. At pcOut = FFFE with a plain advance → pcOut = 0000.
- call with jumpTarget = 0100 at pcOut = 0020, then ret → pcOut = 0100, then 0022.
- 5 nested calls (STACK_DEPTH = 4) → stackOverflow = 1; 4 rets return the 4 most recent addresses; 5th ret sets stackUnderflow and PC increments by 2.
- stall=1 together with jumpTake, and halt then resume → pcOut unchanged during stall; pcValid 0 in HALT; PC resumes from the held value.
- resetN pulsed low mid-cycle during a call → pcOut = 0000, count 0, flags 0 immediately, before the next clock edge.
